// File: rtl/epl_serial_bridge.sv
// Parametrised EPL serial bridge: shifts a parallel word through an external
// shift-register chain, latches it with SLE and returns the captured word.
//
// state    | meaning
// S_IDLE   | waiting for start (or auto restart)
// S_LOAD   | load word, present first SDI bit
// S_SHIFT  | toggle SCLK, capture SDO on rise, drive SDI on fall
// S_LATCH  | SLE high for CLK_DIV cycles
// S_UPDATE | port_o refreshed, done pulse
module epl_serial_bridge #(
  parameter int WIDTH     = 32,
  parameter int CLK_DIV   = 1,
  parameter int MSB_FIRST = 1,
  parameter int AUTO      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] port_i,
  output logic [WIDTH-1:0] port_o,
  output logic             busy,
  output logic             done,
  output logic             EPL_SCLK,
  output logic             EPL_SDI,
  input  logic             EPL_SDO,
  output logic             EPL_SLE,
  input  logic             EPL_INT,
  output logic             int_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_UPDATE
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic             int_s1;

  logic             div_tc;
  logic             sclk_rise;
  logic             sclk_fall;
  logic             out_bit;
  logic [WIDTH-1:0] shifted;

  assign div_tc    = (div_cnt == DW'(CLK_DIV - 1));
  assign sclk_rise = (state == S_SHIFT) && div_tc && !EPL_SCLK;
  assign sclk_fall = (state == S_SHIFT) && div_tc && EPL_SCLK;
  assign busy      = (state != S_IDLE);

  // After a rising edge the next outgoing bit sits at the shift-out end.
  assign out_bit = (MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0];
  assign shifted = (MSB_FIRST != 0) ? {shift_reg[WIDTH-2:0], EPL_SDO}
                                    : {EPL_SDO, shift_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if ((AUTO != 0) || start) next_state = S_LOAD;
      S_LOAD:   next_state = S_SHIFT;
      S_SHIFT:  if (sclk_fall && (bit_cnt == '0)) next_state = S_LATCH;
      S_LATCH:  if (div_tc) next_state = S_UPDATE;
      S_UPDATE: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      port_o    <= '0;
      done      <= 1'b0;
      EPL_SCLK  <= 1'b0;
      EPL_SDI   <= 1'b0;
      EPL_SLE   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_LOAD: begin
          shift_reg <= port_i;
          bit_cnt   <= CW'(WIDTH);
          div_cnt   <= '0;
          EPL_SDI   <= (MSB_FIRST != 0) ? port_i[WIDTH-1] : port_i[0];
        end
        S_SHIFT: begin
          div_cnt <= div_tc ? '0 : div_cnt + DW'(1);
          if (div_tc) EPL_SCLK <= ~EPL_SCLK;
          if (sclk_rise) begin
            shift_reg <= shifted;
            bit_cnt   <= bit_cnt - CW'(1);
          end
          if (sclk_fall) begin
            if (bit_cnt != '0) EPL_SDI <= out_bit;
            else               EPL_SLE <= 1'b1;
          end
        end
        S_LATCH: begin
          div_cnt <= div_tc ? '0 : div_cnt + DW'(1);
          if (div_tc) begin
            EPL_SLE <= 1'b0;
            port_o  <= shift_reg;
            done    <= 1'b1;
          end
        end
        default: div_cnt <= '0;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous chain interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_s1 <= 1'b0;
      int_o  <= 1'b0;
    end else begin
      int_s1 <= EPL_INT;
      int_o  <= int_s1;
    end
  end

endmodule

// File: tb/tb_epl_serial_bridge.sv
// Self-checking bench for epl_serial_bridge: three configurations sharing one
// clock, each frame checked against a queue/arithmetic model of the chain.
module tb_epl_serial_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic ext_int;

  // a: WIDTH=8, CLK_DIV=1, MSB first, on demand; SDO from loopback or chain model
  logic       a_start, a_busy, a_done, a_sclk, a_sdi, a_sle, a_int_o;
  logic [7:0] a_port_i, a_port_o;
  logic       a_loop, a_sdo_drv, a_sdo;
  assign a_sdo = a_loop ? a_sdi : a_sdo_drv;

  // b: WIDTH=8, CLK_DIV=1, LSB first, free running, loopback
  logic       b_start, b_busy, b_done, b_sclk, b_sdi, b_sle, b_int_o;
  logic [7:0] b_port_i, b_port_o;

  // c: WIDTH=4, CLK_DIV=3, MSB first, on demand, loopback
  logic       c_start, c_busy, c_done, c_sclk, c_sdi, c_sle, c_int_o;
  logic [3:0] c_port_i, c_port_o;

  epl_serial_bridge #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1), .AUTO(0)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .port_i(a_port_i), .port_o(a_port_o),
    .busy(a_busy), .done(a_done), .EPL_SCLK(a_sclk), .EPL_SDI(a_sdi), .EPL_SDO(a_sdo),
    .EPL_SLE(a_sle), .EPL_INT(ext_int), .int_o(a_int_o));

  epl_serial_bridge #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(0), .AUTO(1)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .port_i(b_port_i), .port_o(b_port_o),
    .busy(b_busy), .done(b_done), .EPL_SCLK(b_sclk), .EPL_SDI(b_sdi), .EPL_SDO(b_sdi),
    .EPL_SLE(b_sle), .EPL_INT(ext_int), .int_o(b_int_o));

  epl_serial_bridge #(.WIDTH(4), .CLK_DIV(3), .MSB_FIRST(1), .AUTO(0)) u_c (
    .clk(clk), .reset(reset), .start(c_start), .port_i(c_port_i), .port_o(c_port_o),
    .busy(c_busy), .done(c_done), .EPL_SCLK(c_sclk), .EPL_SDI(c_sdi), .EPL_SDO(c_sdi),
    .EPL_SLE(c_sle), .EPL_INT(ext_int), .int_o(c_int_o));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One on-demand frame on u_a. Latency is counted from the LOAD-entry edge.
  task automatic run_a(input logic [7:0] word, input bit chain_mode,
                       input logic [7:0] preload, input bit poke_start);
    int cyc, rises, sle_cyc, idx, extra;
    logic prev_sclk;
    logic [7:0] sent, got_sle;
    bit finished;
    cyc = 0; rises = 0; sle_cyc = 0; idx = 0; extra = 0;
    sent = '0; got_sle = '0; finished = 0;
    a_port_i  = word;
    a_loop    = !chain_mode;
    a_sdo_drv = preload[7];
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("a_busy_in_load", a_busy, 1'b1);
    prev_sclk = a_sclk;
    while (!finished && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 1) a_port_i = 8'($urandom);
      if (poke_start && cyc == 5) a_start = 1'b1;
      if (cyc == 6) a_start = 1'b0;
      if (a_sclk && !prev_sclk) begin
        rises++;
        sent = {sent[6:0], a_sdi};
        idx++;
        if (idx < 8) a_sdo_drv = preload[7-idx];
      end
      if (a_sle) begin
        sle_cyc++;
        got_sle = sent;
      end
      prev_sclk = a_sclk;
      if (a_done) finished = 1;
    end
    chk("a_done_latency", cyc, 18);
    chk("a_sclk_pulses", rises, 8);
    chk("a_sle_cycles", sle_cyc, 1);
    chk("a_sdi_order", sent, word);
    chk("a_chain_latched", got_sle, word);
    chk("a_port_o", a_port_o, chain_mode ? preload : word);
    tick();
    chk("a_busy_after", a_busy, 1'b0);
    chk("a_done_pulse_width", a_done, 1'b0);
    if (poke_start) begin
      for (int t = 0; t < 25; t++) begin
        tick();
        if (a_done || a_busy) extra++;
      end
      chk("a_start_ignored", extra, 0);
    end
  endtask

  task automatic run_c(input logic [3:0] word);
    int cyc, rises, sle_cyc, first_sle, hi_run, bad_hi, bad_per, last_rise;
    logic prev_sclk;
    bit finished;
    cyc = 0; rises = 0; sle_cyc = 0; first_sle = -1; hi_run = 0;
    bad_hi = 0; bad_per = 0; last_rise = -1; finished = 0;
    c_port_i = word;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    prev_sclk = c_sclk;
    while (!finished && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 1) c_port_i = 4'($urandom);
      if (c_sclk) hi_run++;
      else if (hi_run != 0) begin
        if (hi_run != 3) bad_hi++;
        hi_run = 0;
      end
      if (c_sclk && !prev_sclk) begin
        if (last_rise >= 0 && cyc - last_rise != 6) bad_per++;
        if (last_rise < 0 && cyc != 4) bad_per++;
        last_rise = cyc;
        rises++;
      end
      if (c_sle) begin
        sle_cyc++;
        if (first_sle < 0) first_sle = cyc;
      end
      prev_sclk = c_sclk;
      if (c_done) finished = 1;
    end
    chk("c_done_latency", cyc, 28);
    chk("c_sclk_pulses", rises, 4);
    chk("c_sclk_high_3", bad_hi, 0);
    chk("c_sclk_period_6", bad_per, 0);
    chk("c_shift_length", first_sle - 1, 24);
    chk("c_sle_cycles", sle_cyc, 3);
    chk("c_port_o", c_port_o, word);
    tick();
    chk("c_busy_after", c_busy, 1'b0);
  endtask

  initial begin
    int last_done, bad_int, ndone, brises, act, guard, rcount;
    logic [7:0] bword, nv, got;
    logic bprev;
    bit collecting, collected;

    reset = 1'b0; ext_int = 1'b0;
    a_start = 1'b0; a_port_i = '0; a_loop = 1'b1; a_sdo_drv = 1'b0;
    b_start = 1'b0; b_port_i = 8'h3C;
    c_start = 1'b0; c_port_i = '0;

    tick(); tick();
    chk("rst_port_o", a_port_o, 8'h00);
    chk("rst_busy", {a_busy, b_busy, c_busy}, 3'b000);
    chk("rst_done", a_done, 1'b0);
    chk("rst_serial", {a_sclk, a_sdi, a_sle, b_sclk, b_sle}, 5'b0);
    chk("rst_int_o", a_int_o, 1'b0);
    reset = 1'b1;
    tick();

    run_a(8'hA5, 0, 8'h00, 0);
    run_a(8'h00, 1, 8'h3C, 0);
    for (int i = 0; i < 4; i++) run_a(8'($urandom), bit'($urandom_range(0, 1)), 8'($urandom), 0);
    run_a(8'($urandom), 0, 8'h00, 1);

    run_c(4'hB);
    run_c(4'($urandom));

    // Free-running instance: period, LSB-first order, start ignored.
    last_done = -1; bad_int = 0; ndone = 0; brises = 0; bword = '0;
    collecting = 0; collected = 0; bprev = b_sclk;
    for (int t = 0; t < 120; t++) begin
      b_start = 1'($urandom_range(0, 1));
      tick();
      if (b_sclk && !bprev && collecting) begin
        if (brises < 8) bword = bword | (8'(b_sdi) << brises);
        brises++;
      end
      bprev = b_sclk;
      if (b_done) begin
        if (last_done >= 0 && t - last_done != 20) bad_int++;
        last_done = t;
        ndone++;
        chk("b_port_o", b_port_o, 8'h3C);
        if (collecting) begin
          collecting = 0;
          collected  = 1;
        end else if (!collected) collecting = 1;
      end
    end
    chk("b_done_period_20", bad_int, 0);
    chk("b_done_count", ndone >= 5, 1);
    chk("b_sclk_pulses", brises, 8);
    chk("b_sdi_lsb_first", bword, 8'h3C);

    nv = 8'($urandom);
    b_port_i = nv;
    got = ~nv; ndone = 0;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (b_done) begin
        ndone++;
        if (ndone == 2) got = b_port_o;
      end
    end
    b_start = 1'b0;
    chk("b_new_word", got, nv);

    // Interrupt synchroniser latency, with a frame starting alongside.
    ext_int = 1'b0;
    tick(); tick(); tick();
    chk("int_low", a_int_o, 1'b0);
    ext_int = 1'b1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("int_edge1", a_int_o, 1'b0);
    tick();
    chk("int_edge2", a_int_o, 1'b1);
    chk("int_other_inst", {b_int_o, c_int_o}, 2'b11);
    guard = 0;
    while (!a_done && guard < 100) begin tick(); guard++; end
    chk("int_frame_done", a_done, 1'b1);
    tick();

    // Asynchronous reset in the middle of SHIFT.
    run_a(8'h5A, 0, 8'h00, 0);
    a_loop = 1'b1;
    a_port_i = 8'hFF;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    rcount = 0; guard = 0; bprev = a_sclk;
    while (rcount < 3 && guard < 50) begin
      tick();
      guard++;
      if (a_sclk && !bprev) rcount++;
      bprev = a_sclk;
    end
    chk("rst_mid_reached", rcount, 3);
    #2 reset = 1'b0;
    #1;
    chk("rstm_port_o", a_port_o, 8'h00);
    chk("rstm_busy_done", {a_busy, a_done}, 2'b00);
    chk("rstm_serial", {a_sclk, a_sdi, a_sle}, 3'b000);
    chk("rstm_int_o", a_int_o, 1'b0);
    tick(); tick();
    reset = 1'b1;
    act = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (a_busy || a_sclk || a_done) act++;
    end
    chk("rst_no_activity", act, 0);
    chk("rst_port_o_held", a_port_o, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
